// File: rtl/stopwatch_core.sv
// Stopwatch core: BCD mm:ss.cc live time with IDLE/RUN/HOLD/SPLIT control,
// lap freeze of the display and optional saturation at 59:59.99.
module stopwatch_core #(
    parameter bit SAT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic [3:0] cs1,
    output logic [3:0] cs10,
    output logic [3:0] s1,
    output logic [3:0] s10,
    output logic [3:0] m1,
    output logic [3:0] m10,
    output logic       running,
    output logic       split,
    output logic       ovf
);

    localparam int unsigned DIGITS = 6;
    localparam int unsigned DW     = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_SPLIT = 2'd3;

    // Per-digit rollover value, index 0 = cs1 ... index 5 = m10
    localparam logic [DIGITS-1:0][DW-1:0] DIGIT_MAX = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

    logic [1:0]                  state, state_n;
    logic [DIGITS-1:0][DW-1:0]   live, live_n, live_inc;
    logic [DIGITS-1:0][DW-1:0]   disp, disp_n;
    logic                        ovf_n;
    logic                        at_max;
    logic                        counting;

    assign counting = tick && ((state == ST_RUN) || (state == ST_SPLIT));

    // Single-cycle ripple increment of the live time
    always_comb begin
        logic carry;
        live_inc = live;
        carry    = 1'b1;
        at_max   = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (live[i] != DIGIT_MAX[i]) begin
                at_max = 1'b0;
            end
            if (carry) begin
                if (live[i] == DIGIT_MAX[i]) begin
                    live_inc[i] = '0;
                end else begin
                    live_inc[i] = live[i] + DW'(1);
                    carry       = 1'b0;
                end
            end
        end
    end

    // Next state, live time, overflow and display
    always_comb begin
        state_n = state;
        live_n  = live;
        ovf_n   = ovf;
        disp_n  = disp;
        if (clear) begin
            state_n = ST_IDLE;
            live_n  = '0;
            ovf_n   = 1'b0;
        end else begin
            if (start_stop) begin
                case (state)
                    ST_IDLE:  state_n = ST_RUN;
                    ST_RUN:   state_n = ST_HOLD;
                    ST_HOLD:  state_n = ST_RUN;
                    ST_SPLIT: state_n = ST_HOLD;
                    default:  state_n = ST_IDLE;
                endcase
            end else if (lap) begin
                if (state == ST_RUN) begin
                    state_n = ST_SPLIT;
                end else if (state == ST_SPLIT) begin
                    state_n = ST_RUN;
                end
            end
            if (counting) begin
                if (at_max) begin
                    ovf_n = 1'b1;
                    if (SAT) begin
                        state_n = ST_HOLD;
                    end else begin
                        live_n = '0;
                    end
                end else begin
                    live_n = live_inc;
                end
            end
        end
        // Display freezes only while staying in SPLIT; entry captures the new live time
        if (!((state == ST_SPLIT) && (state_n == ST_SPLIT))) begin
            disp_n = live_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            live    <= '0;
            disp    <= '0;
            ovf     <= 1'b0;
            running <= 1'b0;
            split   <= 1'b0;
        end else begin
            state   <= state_n;
            live    <= live_n;
            disp    <= disp_n;
            ovf     <= ovf_n;
            running <= (state_n == ST_RUN) || (state_n == ST_SPLIT);
            split   <= (state_n == ST_SPLIT);
        end
    end

    assign {m10, m1, s10, s1, cs10, cs1} = disp;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: saturating and wrapping instances share stimulus and
// are checked every cycle against a centisecond-count model plus literal checkpoints.
module tb_stopwatch_core;

    localparam int MAXT = 359999;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic start_stop = 1'b0;
    logic lap = 1'b0;
    logic clear = 1'b0;

    logic [3:0] cs1_o [2];
    logic [3:0] cs10_o[2];
    logic [3:0] s1_o  [2];
    logic [3:0] s10_o [2];
    logic [3:0] m1_o  [2];
    logic [3:0] m10_o [2];
    logic       running_o[2];
    logic       split_o  [2];
    logic       ovf_o    [2];

    int checks = 0;
    int errors = 0;

    // Model: time in centiseconds, state 0=IDLE 1=RUN 2=HOLD 3=SPLIT
    int m_t[2];
    int m_st[2];
    int m_disp[2];
    bit m_ovf[2];

    stopwatch_core #(.SAT(1'b1)) u_sat (
        .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .lap(lap), .clear(clear),
        .cs1(cs1_o[0]), .cs10(cs10_o[0]), .s1(s1_o[0]), .s10(s10_o[0]), .m1(m1_o[0]), .m10(m10_o[0]),
        .running(running_o[0]), .split(split_o[0]), .ovf(ovf_o[0])
    );

    stopwatch_core #(.SAT(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .lap(lap), .clear(clear),
        .cs1(cs1_o[1]), .cs10(cs10_o[1]), .s1(s1_o[1]), .s10(s10_o[1]), .m1(m1_o[1]), .m10(m10_o[1]),
        .running(running_o[1]), .split(split_o[1]), .ovf(ovf_o[1])
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] to_bcd(input int v);
        int cs, s, m;
        cs = v % 100;
        s  = (v / 100) % 60;
        m  = v / 6000;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
    endfunction

    function automatic logic [23:0] dut_digits(input int k);
        return {m10_o[k], m1_o[k], s10_o[k], s1_o[k], cs10_o[k], cs1_o[k]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_t[k] = 0; m_st[k] = 0; m_disp[k] = 0; m_ovf[k] = 1'b0;
        end
    endtask

    task automatic model_step(input bit tk, input bit ss, input bit lp, input bit cl);
        for (int k = 0; k < 2; k++) begin
            int  nst;
            bit  active;
            active = (m_st[k] == 1) || (m_st[k] == 3);
            if (rst || cl) begin
                m_t[k] = 0; m_st[k] = 0; m_disp[k] = 0; m_ovf[k] = 1'b0;
            end else begin
                nst = m_st[k];
                if (ss)                        nst = active ? 2 : 1;
                else if (lp && m_st[k] == 1)   nst = 3;
                else if (lp && m_st[k] == 3)   nst = 1;
                if (tk && active) begin
                    if (m_t[k] == MAXT) begin
                        m_ovf[k] = 1'b1;
                        if (k == 0) nst = 2;
                        else        m_t[k] = 0;
                    end else begin
                        m_t[k] = m_t[k] + 1;
                    end
                end
                if (!(m_st[k] == 3 && nst == 3)) m_disp[k] = m_t[k];
                m_st[k] = nst;
            end
        end
    endtask

    task automatic cyc(input bit tk, input bit ss, input bit lp, input bit cl);
        tick = tk; start_stop = ss; lap = lp; clear = cl;
        @(posedge clk);
        model_step(tk, ss, lp, cl);
        #1;
        tick = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input int k, input logic [23:0] d,
                       input bit r, input bit s, input bit o);
        logic [26:0] act, req;
        act = {dut_digits(k), running_o[k], split_o[k], ovf_o[k]};
        req = {d, r, s, o};
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s inst=%0d actual digits/run/split/ovf=%h_%b%b%b required=%h_%b%b%b",
                     name, k, act[26:3], act[2], act[1], act[0], d, r, s, o);
        end
    endtask

    task automatic chk2(input string name, input logic [23:0] d, input bit r, input bit s, input bit o);
        chk(name, 0, d, r, s, o);
        chk(name, 1, d, r, s, o);
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [26:0] act, req;
            act = {dut_digits(k), running_o[k], split_o[k], ovf_o[k]};
            req = {to_bcd(m_disp[k]), (m_st[k] == 1) || (m_st[k] == 3), m_st[k] == 3, m_ovf[k]};
            checks++;
            if (act !== req) begin
                errors++;
                $display("FAIL model_cmp inst=%0d t=%0t actual=%h required=%h", k, $time, act, req);
            end
        end
    end

    initial begin
        model_reset();
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        chk2("reset", 24'h000000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        ticks(3);
        chk2("idle_no_count", 24'h000000, 1'b0, 1'b0, 1'b0);

        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(123);
        chk2("run_123", 24'h000123, 1'b1, 1'b0, 1'b0);
        ticks(876);
        chk2("at_9_99", 24'h000999, 1'b1, 1'b0, 1'b0);
        ticks(1);
        chk2("carry_10s", 24'h001000, 1'b1, 1'b0, 1'b0);
        ticks(4999);
        chk2("at_59_99", 24'h005999, 1'b1, 1'b0, 1'b0);
        ticks(1);
        chk2("carry_min", 24'h010000, 1'b1, 1'b0, 1'b0);

        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk2("clear_run", 24'h000000, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(500);
        chk2("at_5_00", 24'h000500, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(50);
        chk2("split_hold", 24'h000500, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk2("split_release", 24'h000550, 1'b1, 1'b0, 1'b0);

        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk2("clear_prio", 24'h000000, 1'b0, 1'b0, 1'b0);

        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(7);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk2("ss_over_lap", 24'h000008, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk2("hold_ignore", 24'h000008, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk2("split_capture_tick", 24'h000009, 1'b1, 1'b1, 1'b0);
        ticks(5);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk2("split_to_hold", 24'h000015, 1'b0, 1'b0, 1'b0);

        // Jump the live time to 59:59.99 while in HOLD
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        force u_sat.live  = 24'h595999;
        force u_wrap.live = 24'h595999;
        #1;
        release u_sat.live;
        release u_wrap.live;
        m_t[0] = MAXT;
        m_t[1] = MAXT;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk2("preload", 24'h595999, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("sat_ovf", 0, 24'h595999, 1'b0, 1'b0, 1'b1);
        chk("wrap_ovf", 1, 24'h000000, 1'b1, 1'b0, 1'b1);
        ticks(2);
        chk("sat_stays", 0, 24'h595999, 1'b0, 1'b0, 1'b1);
        chk("wrap_counts", 1, 24'h000002, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("sat_split_at_max", 0, 24'h595999, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("sat_split_ovf", 0, 24'h595999, 1'b0, 1'b0, 1'b1);
        chk("wrap_hold_sticky", 1, 24'h000002, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk2("clear_ovf", 24'h000000, 1'b0, 1'b0, 1'b0);

        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(20);
        chk2("pre_rst", 24'h000020, 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk2("async_rst", 24'h000000, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        ticks(5);
        chk2("post_rst", 24'h000000, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(4);
        chk2("restart", 24'h000004, 1'b1, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
